// File: rtl/cam_pkg.sv
// Shared types and constants for the DVP-style camera pixel transmitter.
// Timing defaults describe a QVGA frame with a short vertical blanking period.
package cam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_V_BACK,
        ST_ACTIVE_LINE,
        ST_H_BLANK,
        ST_V_FRONT
    } state_t;

    localparam int DEF_H_ACTIVE      = 320;
    localparam int DEF_V_ACTIVE      = 240;
    localparam int DEF_H_BLANK       = 144;
    localparam int DEF_VSYNC_LINES   = 3;
    localparam int DEF_V_BACK_LINES  = 17;
    localparam int DEF_V_FRONT_LINES = 10;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    function automatic int max4(input int a, input int b,
                                input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cam_bar_gen.sv
// Colour-bar lookup: maps a pixel column to one of eight RGB565 bars.
// Columns past the last full bar fall into the final (black) bar.
module cam_bar_gen
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int XW       = cnt_w(DEF_H_ACTIVE)
) (
    input  logic [XW-1:0] x,
    output logic [15:0]   colour
);

    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    int unsigned bar;

    always_comb begin
        bar    = 32'(x) / 32'(BAR_W);
        colour = BAR_BLACK;
        case (bar)
            0:       colour = BAR_WHITE;
            1:       colour = BAR_YELLOW;
            2:       colour = BAR_CYAN;
            3:       colour = BAR_GREEN;
            4:       colour = BAR_MAGENTA;
            5:       colour = BAR_RED;
            6:       colour = BAR_BLUE;
            default: colour = BAR_BLACK;
        endcase
    end

endmodule

// File: rtl/cam_pixel_tx.sv
// Camera-style parallel pixel transmitter: pclk = clk/2, vsync/href framing,
// RGB565 pixels sent high byte first from a stream or an internal bar pattern.
module cam_pixel_tx
    import cam_pkg::*;
#(
    parameter int H_ACTIVE      = DEF_H_ACTIVE,
    parameter int V_ACTIVE      = DEF_V_ACTIVE,
    parameter int H_BLANK       = DEF_H_BLANK,
    parameter int VSYNC_LINES   = DEF_VSYNC_LINES,
    parameter int V_BACK_LINES  = DEF_V_BACK_LINES,
    parameter int V_FRONT_LINES = DEF_V_FRONT_LINES
) (
    input  logic        clk_65mhz,
    input  logic        rst_n_in,
    input  logic        enable_in,
    input  logic        pattern_mode_in,
    input  logic [15:0] pixel_in,
    input  logic        pixel_valid_in,
    output logic        pixel_ready_out,
    output logic        cam_clk_out,
    output logic        vsync_out,
    output logic        href_out,
    output logic [7:0]  pixel_out,
    output logic        frame_start_out,
    output logic        underflow_out
);

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int HW = cnt_w(LINE_LEN);
    localparam int LW = cnt_w(max4(VSYNC_LINES, V_BACK_LINES,
                                   V_ACTIVE, V_FRONT_LINES));
    localparam int XW = cnt_w(H_ACTIVE);

    localparam logic [HW-1:0] H_LAST    = HW'(LINE_LEN - 1);
    localparam logic [HW-1:0] HREF_LAST = HW'(2 * H_ACTIVE - 1);
    localparam logic [LW-1:0] VS_LAST   = LW'(VSYNC_LINES - 1);
    localparam logic [LW-1:0] VB_LAST   = LW'(V_BACK_LINES - 1);
    localparam logic [LW-1:0] VA_LAST   = LW'(V_ACTIVE - 1);
    localparam logic [LW-1:0] VF_LAST   = LW'(V_FRONT_LINES - 1);

    state_t          state, nstate;
    logic [HW-1:0]   hcnt, nh;
    logic [LW-1:0]   lcnt, nl;
    logic            start;
    logic            tick;
    logic            h_wrap;
    logic            pattern_q;
    logic [7:0]      lo_byte;
    logic            load_hi;
    logic [XW-1:0]   px;
    logic [15:0]     bar_colour;
    logic [15:0]     cur_pix;

    assign tick   = cam_clk_out;
    assign h_wrap = (hcnt == H_LAST);

    always_comb begin
        nstate = state;
        nh     = h_wrap ? '0 : hcnt + 1'b1;
        nl     = lcnt;
        start  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                nh = '0;
                nl = '0;
                if (enable_in) begin
                    nstate = ST_VSYNC;
                    start  = 1'b1;
                end
            end
            ST_VSYNC: begin
                if (h_wrap) begin
                    if (lcnt == VS_LAST) begin
                        nstate = ST_V_BACK;
                        nl     = '0;
                    end else begin
                        nl = lcnt + 1'b1;
                    end
                end
            end
            ST_V_BACK: begin
                if (h_wrap) begin
                    if (lcnt == VB_LAST) begin
                        nstate = ST_ACTIVE_LINE;
                        nl     = '0;
                    end else begin
                        nl = lcnt + 1'b1;
                    end
                end
            end
            ST_ACTIVE_LINE: begin
                if (hcnt == HREF_LAST) nstate = ST_H_BLANK;
            end
            ST_H_BLANK: begin
                if (h_wrap) begin
                    if (lcnt == VA_LAST) begin
                        nstate = ST_V_FRONT;
                        nl     = '0;
                    end else begin
                        nstate = ST_ACTIVE_LINE;
                        nl     = lcnt + 1'b1;
                    end
                end
            end
            ST_V_FRONT: begin
                if (h_wrap) begin
                    if (lcnt == VF_LAST) begin
                        nl = '0;
                        if (enable_in) begin
                            nstate = ST_VSYNC;
                            start  = 1'b1;
                        end else begin
                            nstate = ST_IDLE;
                        end
                    end else begin
                        nl = lcnt + 1'b1;
                    end
                end
            end
            default: nstate = ST_IDLE;
        endcase
    end

    // Even pclk slots of an active line carry the high byte of a new pixel.
    assign load_hi         = (nstate == ST_ACTIVE_LINE) && !nh[0];
    assign pixel_ready_out = tick && load_hi && !pattern_q;
    assign px              = XW'(nh >> 1);

    cam_bar_gen #(
        .H_ACTIVE (H_ACTIVE),
        .XW       (XW)
    ) u_bar_gen (
        .x      (px),
        .colour (bar_colour)
    );

    always_comb begin
        cur_pix = 16'h0000;
        if (pattern_q)           cur_pix = bar_colour;
        else if (pixel_valid_in) cur_pix = pixel_in;
    end

    always_ff @(posedge clk_65mhz or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= ST_IDLE;
            hcnt            <= '0;
            lcnt            <= '0;
            cam_clk_out     <= 1'b0;
            vsync_out       <= 1'b0;
            href_out        <= 1'b0;
            pixel_out       <= '0;
            frame_start_out <= 1'b0;
            underflow_out   <= 1'b0;
            pattern_q       <= 1'b0;
            lo_byte         <= '0;
        end else begin
            cam_clk_out     <= ~cam_clk_out;
            frame_start_out <= 1'b0;
            if (tick) begin
                state           <= nstate;
                hcnt            <= nh;
                lcnt            <= nl;
                frame_start_out <= start;
                if (start) pattern_q <= pattern_mode_in;
                vsync_out <= (nstate == ST_VSYNC);
                href_out  <= (nstate == ST_ACTIVE_LINE);
                if (load_hi) begin
                    pixel_out <= cur_pix[15:8];
                    lo_byte   <= cur_pix[7:0];
                end else if (nstate == ST_ACTIVE_LINE) begin
                    pixel_out <= lo_byte;
                end else begin
                    pixel_out <= '0;
                end
                if (pixel_ready_out && !pixel_valid_in) underflow_out <= 1'b1;
            end
        end
    end

endmodule

// File: doc/cam_pixel_tx.md
CAM_PIXEL_TX -- requirements
Module: cam_pixel_tx

Interface
REQ-001 SHALL have parameters: H_ACTIVE, default 320, pixels per line; V_ACTIVE, default 240, active lines per frame; H_BLANK, default 144, pclk periods of href-low per line; VSYNC_LINES, default 3; V_BACK_LINES, default 17; V_FRONT_LINES, default 10.
REQ-002 SHALL have ports:
- clk_65mhz  in  1  sole clock
- rst_n_in  in  1  asynchronous, active-low reset
- enable_in  in  1  run frames
- pattern_mode_in  in  1  1 = internal colour bars, 0 = streamed pixels
- pixel_in  in  16  RGB565 pixel
- pixel_valid_in  in  1  pixel_in valid
- pixel_ready_out  out  1  pixel accepted when high with valid
- cam_clk_out  out  1  pixel clock
- vsync_out  out  1  frame sync
- href_out  out  1  line valid
- pixel_out  out  8  byte bus
- frame_start_out  out  1  one-cycle pulse
- underflow_out  out  1  sticky starvation flag

Function
REQ-003 SHALL toggle cam_clk_out every clk_65mhz cycle (pclk = clk/2); a "tick" is a cycle in which cam_clk_out is 1.
REQ-004 SHALL update vsync_out, href_out and pixel_out only on ticks, i.e. with the falling edge of cam_clk_out, so all are stable at its rising edge.
REQ-005 SHALL implement states IDLE, VSYNC, V_BACK, ACTIVE_LINE, H_BLANK and V_FRONT. Line length is 2*H_ACTIVE + H_BLANK pclks in every state except IDLE.
REQ-006 In IDLE, on a tick with enable_in=1, SHALL go to VSYNC, sample pattern_mode_in for the whole frame, and pulse frame_start_out for one clk.
REQ-007 SHALL hold vsync_out=1 only in VSYNC (VSYNC_LINES lines), then go to V_BACK (V_BACK_LINES lines), then to ACTIVE_LINE.
REQ-008 Each active line SHALL drive href_out=1 for exactly 2*H_ACTIVE pclks, then href_out=0 for H_BLANK pclks, alternating V_ACTIVE times.
REQ-009 Byte order SHALL be pixel[15:8] first, then pixel[7:0]; the byte count per line is always even.
REQ-010 After the last active line, SHALL spend V_FRONT_LINES lines in V_FRONT, then return to VSYNC if enable_in=1, else to IDLE.
REQ-011 enable_in deassertion mid-frame SHALL NOT truncate the frame; it is sampled only at frame end and in IDLE.
REQ-012 Streamed mode: pixel_ready_out SHALL be 1 for exactly the clk cycle of each tick that loads a high byte. Transfer occurs iff pixel_valid_in && pixel_ready_out. The high byte appears on pixel_out at that edge and the low byte 2 clk later.
REQ-013 If pixel_valid_in=0 while ready, SHALL send 16'h0000 for that pixel, set underflow_out=1 (sticky until reset), and keep frame timing unchanged.
REQ-014 Pattern mode: pixel_ready_out SHALL stay 0. Pixels SHALL be 8 equal bars of H_ACTIVE/8 px: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000, left to right, repeated on every line.
REQ-015 pixel_out SHALL be 8'h00 whenever href_out=0.
REQ-016 Horizontal counter width SHALL be clog2(2*H_ACTIVE+H_BLANK); the line counter SHALL be sized for the largest per-state count. Counters wrap to 0 at each state or line boundary, with no off-by-one.

Reset
REQ-017 While rst_n_in=0 SHALL force IDLE, all counters 0, cam_clk_out=0, vsync_out=0, href_out=0, pixel_out=0, pixel_ready_out=0, frame_start_out=0, underflow_out=0.
REQ-018 Reset assertion mid-line SHALL take effect immediately (asynchronously). After release, the first frame begins with VSYNC, not mid-frame.

Structure
REQ-019 Package cam_pkg SHALL hold the state enum, the default timing constants and the 8 bar colour constants.
REQ-020 Bar colour selection SHALL be a sub-module cam_bar_gen (x position in, 16-bit colour out); everything else stays in cam_pixel_tx.

Verification (H_ACTIVE=8, V_ACTIVE=2, H_BLANK=4, VSYNC/V_BACK/V_FRONT_LINES=1)
REQ-021 Release reset with enable=1, pattern=1 -> frame_start pulse; vsync high for 20 pclks; 20 pclks quiet; href high for 16 pclks with bytes FF,FF,FF,E0,07,FF,...,00,00; then 4 pclks low; repeat once.
REQ-022 Streamed mode, valid always 1, pixel_in = A5C3+n -> pixel_out shows A5,C3,A5,C4,... and exactly 8 handshakes per line; underflow stays 0.
REQ-023 Streamed mode, valid dropped for the 3rd pixel of line 0 -> bytes 00,00 in that slot, underflow_out=1 from then on, line length still 16 href pclks.
REQ-024 enable low in the middle of line 1 -> frame completes, including V_FRONT, then IDLE with all sync outputs 0 and no frame_start.
REQ-025 Reset asserted during ACTIVE_LINE -> all outputs 0 in the same cycle; after release, VSYNC restarts cleanly.
REQ-026 Scoreboard SHALL check setup: vsync, href and pixel are never changing at a rising cam_clk_out edge.
